// File: rtl/uart_rx_param_if.sv
// Receive-side output bundle of uart_rx_param.
// The receiver drives it through the master modport and the consumer
// (a FIFO or a CPU register block) uses the slave modport.
//   rx_data    received word, valid while rx_valid=1
//   rx_valid   a word is held in the output register
//   rx_ready   consumer accepts the word when rx_valid && rx_ready
//   parity_err parity mismatch for the held word
//   frame_err  a stop bit was sampled 0 for the held word
//   break_det  held word is a line break (all zero, framing error)
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, break_det,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, break_det,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: DATA_BITS data bits (LSB first), optional
// odd/even parity, 1 or 2 stop bits. Each bit is the 3-sample majority
// around the bit centre. Received words go out through a one-entry
// valid/ready output register.
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   rx       asynchronous serial input, idle high
//   out_if   word, flags and valid/ready handshake (master side)
//   overrun  1-clk pulse when a completed word is dropped (register full)
//   busy     receiver is inside a frame
module uart_rx_param #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx,
  uart_rx_param_if.master  out_if,
  output logic             overrun,
  output logic             busy
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW      = $clog2(OVERSAMPLE);
  localparam int MID     = OVERSAMPLE / 2;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  logic [PW-1:0]        presc_q, presc_d;
  logic [OW-1:0]        os_q, os_d;
  logic [3:0]           bit_q, bit_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 pbit_q, pbit_d;
  logic                 perr_q, perr_d;
  logic                 frame_q, frame_d;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_o_q, ferr_o_q, brk_o_q, ovr_q;

  logic tick, fall, res, wrap, bit_v, exp_par, commit, frame_fin, brk_fin, hs;

  assign tick    = (presc_q == PW'(DIV - 1));
  assign fall    = rx_prev_q & ~rx_s_q;
  assign res     = tick && (os_q == OW'(MID + 1));
  assign wrap    = tick && (os_q == OW'(OVERSAMPLE - 1));
  // Majority of the two stored samples and the live one at resolution.
  assign bit_v   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
  assign exp_par = (PARITY == 1) ? ~^shreg_q : ^shreg_q;
  assign frame_fin = frame_q | ~bit_v;
  // pbit_q stays 0 when there is no parity bit, so it drops out here.
  assign brk_fin = (shreg_q == '0) && !pbit_q && frame_fin;
  assign hs      = valid_q && out_if.rx_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      os_q    <= '0;
      bit_q   <= '0;
      samp_q  <= '0;
      shreg_q <= '0;
      pbit_q  <= 1'b0;
      perr_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      samp_q  <= samp_d;
      shreg_q <= shreg_d;
      pbit_q  <= pbit_d;
      perr_q  <= perr_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    os_d    = os_q;
    bit_d   = bit_q;
    samp_d  = samp_q;
    shreg_d = shreg_q;
    pbit_d  = pbit_q;
    perr_d  = perr_q;
    frame_d = frame_q;
    commit  = 1'b0;

    if (tick) os_d = wrap ? '0 : os_q + 1'b1;
    if (tick && os_q == OW'(MID - 1)) samp_d[0] = rx_s_q;
    if (tick && os_q == OW'(MID))     samp_d[1] = rx_s_q;

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          presc_d = '0;
          os_d    = '0;
          bit_d   = '0;
          pbit_d  = 1'b0;
          perr_d  = 1'b0;
          frame_d = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (res && bit_v) state_d = S_IDLE;
        else if (wrap) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (res) shreg_d = {bit_v, shreg_q[DATA_BITS-1:1]};
        if (wrap) begin
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (res) begin
          pbit_d = bit_v;
          perr_d = (bit_v != exp_par);
        end
        if (wrap) begin
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (res) begin
          frame_d = frame_fin;
          // Commit at the last stop bit's resolution and resync early.
          if (bit_q == 4'(STOP_BITS - 1)) begin
            commit  = 1'b1;
            state_d = S_IDLE;
          end
        end else if (wrap) begin
          bit_d = bit_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_o_q <= 1'b0;
      ferr_o_q <= 1'b0;
      brk_o_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (commit) begin
        if (!valid_q || hs) begin
          data_q   <= shreg_q;
          perr_o_q <= perr_q;
          ferr_o_q <= frame_fin;
          brk_o_q  <= brk_fin;
          valid_q  <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (hs) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_if.rx_data    = data_q;
  assign out_if.rx_valid   = valid_q;
  assign out_if.parity_err = perr_o_q;
  assign out_if.frame_err  = ferr_o_q;
  assign out_if.break_det  = brk_o_q;
  assign overrun           = ovr_q;
  assign busy              = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

  localparam int CLKF = 1000000;
  localparam int BAUD = 15625;
  localparam int OS   = 16;
  localparam int BIT  = (CLKF / (BAUD * OS)) * OS;  // clocks per bit = 64

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       br;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic rx_a, rx_b, rx_c;
  logic ovr_a, ovr_b, ovr_c;
  logic busy_a, busy_b, busy_c;

  always #5 clk = ~clk;

  // A: 8N1, B: 7 bits even parity 1 stop, C: 8 bits odd parity 2 stop
  uart_rx_param_if #(.DATA_BITS(8)) ifa ();
  uart_rx_param_if #(.DATA_BITS(7)) ifb ();
  uart_rx_param_if #(.DATA_BITS(8)) ifc ();

  uart_rx_param #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    dut_a (.clk(clk), .reset_n(reset_n), .rx(rx_a), .out_if(ifa), .overrun(ovr_a), .busy(busy_a));
  uart_rx_param #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                  .DATA_BITS(7), .PARITY(2), .STOP_BITS(1))
    dut_b (.clk(clk), .reset_n(reset_n), .rx(rx_b), .out_if(ifb), .overrun(ovr_b), .busy(busy_b));
  uart_rx_param #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                  .DATA_BITS(8), .PARITY(1), .STOP_BITS(2))
    dut_c (.clk(clk), .reset_n(reset_n), .rx(rx_c), .out_if(ifc), .overrun(ovr_c), .busy(busy_c));

  function automatic int nb_of(input int d);
    return (d == 1) ? 7 : 8;
  endfunction
  function automatic int par_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 1);
  endfunction
  function automatic int stp_of(input int d);
    return (d == 2) ? 2 : 1;
  endfunction

  int   total = 0;
  int   bad   = 0;
  exp_t sbq [3][$];
  int   vcnt [3];
  int   ocnt [3];
  bit   rr_en = 1'b0;

  logic [8:0] m_data [3];
  logic       m_valid [3], m_ready [3], m_pe [3], m_fe [3], m_br [3], m_ovr [3];

  assign m_data[0] = 9'(ifa.rx_data);
  assign m_data[1] = 9'(ifb.rx_data);
  assign m_data[2] = 9'(ifc.rx_data);
  assign m_valid[0] = ifa.rx_valid;  assign m_valid[1] = ifb.rx_valid;  assign m_valid[2] = ifc.rx_valid;
  assign m_ready[0] = ifa.rx_ready;  assign m_ready[1] = ifb.rx_ready;  assign m_ready[2] = ifc.rx_ready;
  assign m_pe[0] = ifa.parity_err;   assign m_pe[1] = ifb.parity_err;   assign m_pe[2] = ifc.parity_err;
  assign m_fe[0] = ifa.frame_err;    assign m_fe[1] = ifb.frame_err;    assign m_fe[2] = ifc.frame_err;
  assign m_br[0] = ifa.break_det;    assign m_br[1] = ifb.break_det;    assign m_br[2] = ifc.break_det;
  assign m_ovr[0] = ovr_a;           assign m_ovr[1] = ovr_b;           assign m_ovr[2] = ovr_c;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s dut=%0d actual=0x%0h required=0x%0h", nm, d, act, req);
    end
  endtask

  // Monitor: a word is newly presented when valid rises or stays high right
  // after a handshake; it is then compared against the scoreboard head.
  logic [8:0] pdata [3];
  logic       pv [3], phs [3], ppe [3], pfe [3], pbr [3];
  exp_t       e_m;

  always @(negedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        pv[i]  = 1'b0;
        phs[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_valid[i] === 1'b1) vcnt[i]++;
        if (m_ovr[i] === 1'b1) ocnt[i]++;
        if (m_valid[i] === 1'b1 && (!pv[i] || phs[i])) begin
          if (sbq[i].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word dut=%0d actual=0x%0h required=none", i, m_data[i]);
          end else begin
            e_m = sbq[i].pop_front();
            chk("rx_data", i, 32'(m_data[i]), 32'(e_m.data));
            chk("parity_err", i, 32'(m_pe[i]), 32'(e_m.pe));
            chk("frame_err", i, 32'(m_fe[i]), 32'(e_m.fe));
            chk("break_det", i, 32'(m_br[i]), 32'(e_m.br));
          end
        end else if (m_valid[i] === 1'b1 && pv[i]) begin
          chk("held_word", i, {19'd0, m_data[i], m_pe[i], m_fe[i], m_br[i]},
                              {19'd0, pdata[i], ppe[i], pfe[i], pbr[i]});
        end
        pv[i]    = (m_valid[i] === 1'b1);
        phs[i]   = (m_valid[i] === 1'b1) && (m_ready[i] === 1'b1);
        pdata[i] = m_data[i];
        ppe[i]   = m_pe[i];
        pfe[i]   = m_fe[i];
        pbr[i]   = m_br[i];
      end
    end
  end

  task automatic set_ready(input int d, input logic v);
    case (d)
      0:       ifa.rx_ready = v;
      1:       ifb.rx_ready = v;
      default: ifc.rx_ready = v;
    endcase
  endtask

  // Random consumer back-pressure; ready changes just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_en) for (int i = 0; i < 3; i++) set_ready(i, 1'($urandom_range(0, 1)));
    end
  end

  task automatic drive_line(input int d, input logic v, input int clks);
    case (d)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
    repeat (clks) @(negedge clk);
  endtask

  // Reference model: frame fields from plain arithmetic on the word sent.
  task automatic send_frame(input int d, input logic [8:0] val, input bit pbad,
                            input bit sbad, input bit push);
    int         nb   = nb_of(d);
    int         par  = par_of(d);
    logic [8:0] v    = val & 9'((1 << nb) - 1);
    int         ones = $countones(v);
    bit         pok  = (par == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
    bit         ps   = pbad ? !pok : pok;
    exp_t       e;
    e.data = v;
    e.pe   = (par != 0) && pbad;
    e.fe   = sbad;
    e.br   = (v == 0) && (par == 0 || !ps) && sbad;
    if (push) sbq[d].push_back(e);
    drive_line(d, 1'b0, BIT);
    for (int i = 0; i < nb; i++) drive_line(d, v[i], BIT);
    if (par != 0) drive_line(d, ps, BIT);
    for (int s = 0; s < stp_of(d); s++) drive_line(d, (s == 0) ? !sbad : 1'b1, BIT);
    drive_line(d, 1'b1, int'($urandom_range(BIT, 2 * BIT)));
  endtask

  initial begin
    int v0, o0;
    exp_t eb;
    for (int i = 0; i < 3; i++) begin
      vcnt[i] = 0;
      ocnt[i] = 0;
    end
    reset_n = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    ifa.rx_ready = 1'b1; ifb.rx_ready = 1'b1; ifc.rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_valid", 0, 32'(ifa.rx_valid), 0);
    chk("reset_data", 0, 32'(ifa.rx_data), 0);
    chk("reset_busy", 0, 32'(busy_a), 0);
    chk("reset_ovr", 0, 32'(ovr_a), 0);
    reset_n = 1'b1;
    repeat (BIT) @(negedge clk);

    // 8N1 word with an always-ready consumer: valid is a single-cycle pulse
    v0 = vcnt[0];
    send_frame(0, 9'h0A5, 1'b0, 1'b0, 1'b1);
    chk("valid_pulse_len", 0, 32'(vcnt[0] - v0), 1);

    // Even parity, 7 bits: clean then wrong parity bit
    send_frame(1, 9'h03C, 1'b0, 1'b0, 1'b1);
    send_frame(1, 9'h03C, 1'b1, 1'b0, 1'b1);

    // Short glitch is a false start
    drive_line(0, 1'b0, 10);
    chk("glitch_busy", 0, 32'(busy_a), 1);
    drive_line(0, 1'b0, 10);
    drive_line(0, 1'b1, 2 * BIT);
    chk("glitch_idle", 0, 32'(busy_a), 0);
    send_frame(0, 9'h081, 1'b0, 1'b0, 1'b1);

    // Overrun: second word dropped while the first is held
    @(posedge clk); #1; ifa.rx_ready = 1'b0;
    o0 = ocnt[0];
    send_frame(0, 9'h011, 1'b0, 1'b0, 1'b1);
    send_frame(0, 9'h022, 1'b0, 1'b0, 1'b0);
    chk("overrun_once", 0, 32'(ocnt[0] - o0), 1);
    chk("held_after_ovr", 0, 32'(ifa.rx_data), 32'h11);
    @(posedge clk); #1; ifa.rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("valid_dropped", 0, 32'(ifa.rx_valid), 0);

    // Framing error, then a two-frame break that yields exactly one word
    send_frame(0, 9'h055, 1'b0, 1'b1, 1'b1);
    eb.data = 9'h000; eb.pe = 1'b0; eb.fe = 1'b1; eb.br = 1'b1;
    sbq[0].push_back(eb);
    drive_line(0, 1'b0, 20 * BIT);
    drive_line(0, 1'b1, 2 * BIT);

    // Reset mid-DATA on the 2-stop receiver while it holds a word
    @(posedge clk); #1; ifc.rx_ready = 1'b0;
    send_frame(2, 9'h0A7, 1'b0, 1'b0, 1'b1);
    chk("c_holding", 2, 32'(ifc.rx_valid), 1);
    drive_line(2, 1'b0, BIT);
    drive_line(2, 1'b1, BIT);
    drive_line(2, 1'b1, BIT);
    drive_line(2, 1'b1, BIT / 2);
    chk("c_busy_mid", 2, 32'(busy_c), 1);
    reset_n = 1'b0;
    #1;
    chk("rst_valid", 2, 32'(ifc.rx_valid), 0);
    chk("rst_data", 2, 32'(ifc.rx_data), 0);
    chk("rst_flags", 2, {29'd0, ifc.parity_err, ifc.frame_err, ifc.break_det}, 0);
    chk("rst_busy_ovr", 2, {30'd0, busy_c, ovr_c}, 0);
    rx_c = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    ifc.rx_ready = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    send_frame(2, 9'h0C3, 1'b0, 1'b0, 1'b1);

    // Randomised frames with random consumer back-pressure
    rr_en = 1'b1;
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 6; k++) begin
        logic [8:0] rv;
        bit pb, sb;
        rv = 9'($urandom_range(0, 511));
        if ($urandom_range(0, 5) == 0) rv = '0;
        pb = (par_of(d) != 0) && ($urandom_range(0, 3) == 0);
        sb = ($urandom_range(0, 3) == 0);
        send_frame(d, rv, pb, sb, 1'b1);
      end
    end
    rr_en = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) set_ready(i, 1'b1);
    repeat (2 * BIT) @(negedge clk);

    for (int i = 0; i < 3; i++) chk("words_left", i, 32'(sbq[i].size()), 0);
    chk("ovr_total", 0, 32'(ocnt[0]), 1);
    chk("ovr_total", 1, 32'(ocnt[1]), 0);
    chk("ovr_total", 2, 32'(ocnt[2]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
